// File: rtl/upscale_pkg.sv
`default_nettype none
// ============================================================================
// Module      : upscale_pkg
// Description : Shared constants, state encoding and helper functions for the
//               pixel-shuffle (depth-to-space, scale 2) output stage.
//               - lane_index : lane number of (colour, sub-row, sub-column)
//               - clamp_u8   : fixed-point lane -> unsigned 8-bit colour
// Revision    : 1.0 - initial release
// ============================================================================
package upscale_pkg;

    localparam int SCALE      = 2;
    localparam int LANES      = 3 * SCALE * SCALE;
    localparam int RGB_WIDTH  = 24;
    localparam int PAIR_WIDTH = 2 * RGB_WIDTH;

    typedef enum logic [2:0] {
        ACCEPT   = 3'd0,
        TOP0     = 3'd1,
        TOP1     = 3'd2,
        DRAIN_RD = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    // Lane layout of one low-res result: colour-major, then sub-row, then sub-column.
    function automatic int lane_index(input int c, input int dy, input int dx);
        return c * SCALE * SCALE + dy * SCALE + dx;
    endfunction

    // Arithmetic shift drops the fraction (floor), then saturate to 0..255.
    function automatic logic [7:0] clamp_u8(input logic signed [31:0] lane,
                                            input int                 frac_bits);
        logic signed [31:0] v;
        v = lane >>> frac_bits;
        if (v < 0)
            return 8'h00;
        else if (v > 32'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/shuffle_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : shuffle_line_buffer
// Description : Simple dual-port RAM holding the bottom sub-row pixel pairs of
//               one low-res row. One write port, one read port with a single
//               registered read stage. Storage is not reset.
// Ports       : clk      - system clock
//               wr_en    - write strobe
//               wr_addr  - write address (low-res column)
//               wr_data  - pixel pair {dx=0, dx=1}
//               rd_en    - read strobe, data valid the following cycle
//               rd_addr  - read address
//               rd_data  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module shuffle_line_buffer #(
    parameter int DEPTH      = 160,
    parameter int WIDTH      = 48,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[wr_addr] <= wr_data;
        if (rd_en)
            r_rd_data <= r_mem[rd_addr];
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/pixel_shuffle_out.sv
`default_nettype none
// ============================================================================
// Module      : pixel_shuffle_out
// Description : Depth-to-space (scale 2) output stage. Each accepted low-res
//               result carries 3 colours x 2x2 sub-pixels. The top sub-row pair
//               is emitted immediately; the bottom pair is parked in a line
//               buffer and drained as the following output row once the whole
//               top row is out. Output is an RGB888 raster stream.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_data/valid/ready - 12-lane signed fixed-point input
//               out_rgb/valid/ready - {R,G,B} output stream
//               out_sof             - first pixel of a frame
//               out_eol             - last pixel of an output row
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_shuffle_out
    import upscale_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int IN_CHANNELS = 3,
    parameter int IN_WIDTH    = 160,
    parameter int IN_HEIGHT   = 120,
    parameter int FRAC_BITS   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [IN_CHANNELS*4*DATA_WIDTH-1:0] in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [23:0]                       out_rgb,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sof,
    output logic                              out_eol
);

    localparam int c_XW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int c_YW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int c_DW = $clog2(2 * IN_WIDTH);

    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(IN_WIDTH - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(IN_HEIGHT - 1);
    localparam logic [c_DW-1:0] c_D_LAST = c_DW'(2 * IN_WIDTH - 1);

    state_t                               r_state;
    logic [c_XW-1:0]                      r_x_cnt;
    logic [c_YW-1:0]                      r_y_cnt;
    logic [c_DW-1:0]                      r_drain_cnt;
    logic [RGB_WIDTH-1:0]                 r_top0;
    logic [RGB_WIDTH-1:0]                 r_top1;
    logic                                 r_in_ready;
    logic                                 r_out_valid;
    logic                                 r_out_sof;
    logic                                 r_out_eol;

    logic [SCALE-1:0][SCALE-1:0][RGB_WIDTH-1:0] w_pix;
    logic                                 w_accept;
    logic [PAIR_WIDTH-1:0]                w_lb_rdata;
    logic [c_XW-1:0]                      w_lb_raddr;

    // Convert every lane of the presented input; R comes from colour 0 and
    // lands in the most significant byte.
    always_comb begin
        w_pix = '0;
        for (int dy = 0; dy < SCALE; dy++) begin
            for (int dx = 0; dx < SCALE; dx++) begin
                for (int c = 0; c < 3; c++) begin
                    w_pix[dy][dx][(2-c)*8 +: 8] = clamp_u8(
                        32'($signed(in_data[lane_index(c, dy, dx)*DATA_WIDTH +: DATA_WIDTH])),
                        FRAC_BITS);
                end
            end
        end
    end

    assign w_accept   = in_valid && r_in_ready;
    assign w_lb_raddr = c_XW'(r_drain_cnt >> 1);

    shuffle_line_buffer #(
        .DEPTH      (IN_WIDTH),
        .WIDTH      (PAIR_WIDTH),
        .ADDR_WIDTH (c_XW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (w_accept),
        .wr_addr (r_x_cnt),
        .wr_data ({w_pix[1][0], w_pix[1][1]}),
        .rd_en   (r_state == DRAIN_RD),
        .rd_addr (w_lb_raddr),
        .rd_data (w_lb_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCEPT;
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_drain_cnt <= '0;
            r_top0      <= '0;
            r_top1      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
        end else begin
            case (r_state)
                ACCEPT: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_top0      <= w_pix[0][0];
                        r_top1      <= w_pix[0][1];
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_sof   <= (r_x_cnt == '0) && (r_y_cnt == '0);
                        r_out_eol   <= 1'b0;
                        r_state     <= TOP0;
                    end
                end
                TOP0: begin
                    if (out_ready) begin
                        r_out_sof <= 1'b0;
                        r_out_eol <= (r_x_cnt == c_X_LAST);
                        r_state   <= TOP1;
                    end
                end
                TOP1: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_eol   <= 1'b0;
                        if (r_x_cnt != c_X_LAST) begin
                            r_x_cnt    <= r_x_cnt + c_XW'(1);
                            r_in_ready <= 1'b1;
                            r_state    <= ACCEPT;
                        end else begin
                            r_x_cnt     <= '0;
                            r_drain_cnt <= '0;
                            r_state     <= DRAIN_RD;
                        end
                    end
                end
                DRAIN_RD: begin
                    // Word is being fetched; it appears on the RAM output as
                    // this state is left, so the pixel becomes valid together.
                    r_out_valid <= 1'b1;
                    r_out_eol   <= (r_drain_cnt == c_D_LAST);
                    r_state     <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_drain_cnt == c_D_LAST) begin
                            r_out_valid <= 1'b0;
                            r_out_eol   <= 1'b0;
                            r_drain_cnt <= '0;
                            r_y_cnt     <= (r_y_cnt == c_Y_LAST) ? '0 : r_y_cnt + c_YW'(1);
                            r_in_ready  <= 1'b1;
                            r_state     <= ACCEPT;
                        end else if (!r_drain_cnt[0]) begin
                            // Second pixel of the same word: no refetch needed.
                            r_drain_cnt <= r_drain_cnt + c_DW'(1);
                            r_out_eol   <= ((r_drain_cnt + c_DW'(1)) == c_D_LAST);
                        end else begin
                            r_drain_cnt <= r_drain_cnt + c_DW'(1);
                            r_out_valid <= 1'b0;
                            r_out_eol   <= 1'b0;
                            r_state     <= DRAIN_RD;
                        end
                    end
                end
                default: begin
                    r_state <= ACCEPT;
                end
            endcase
        end
    end

    // Pixel source follows the state; every source is a register that only
    // changes on a handshake, so the value is stable while stalled.
    always_comb begin
        out_rgb = '0;
        case (r_state)
            TOP0:    out_rgb = r_top0;
            TOP1:    out_rgb = r_top1;
            DRAIN:   out_rgb = r_drain_cnt[0] ? w_lb_rdata[RGB_WIDTH-1:0]
                                              : w_lb_rdata[PAIR_WIDTH-1 -: RGB_WIDTH];
            default: out_rgb = '0;
        endcase
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;

endmodule
`default_nettype wire

// File: tb/tb_pixel_shuffle_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_shuffle_out
// Description : Self-checking bench for pixel_shuffle_out. Two instances share
//               the same stimulus: FRAC_BITS=8 (main) and FRAC_BITS=4, the
//               latter so that the upper saturation limit is reachable with
//               16-bit lanes. Expected pixels come from a raster-order model
//               computed directly from the depth-to-space and clamp rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_shuffle_out;

    localparam int W    = 3;
    localparam int H    = 4;
    localparam int DW   = 16;
    localparam int NL   = 12;
    localparam int LW   = NL * DW;
    localparam int NIN  = W * H;
    localparam int OW   = 2 * W;
    localparam int NPIX = OW * 2 * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, out_sof, out_eol;
    logic [23:0]   out_rgb;
    logic          in_ready4, out_valid4, out_sof4, out_eol4;
    logic [23:0]   out_rgb4;

    int errors = 0;
    int checks = 0;

    logic [LW-1:0] fr   [0:2*NIN-1];
    logic [23:0]   obs  [0:NPIX-1];
    logic [23:0]   obs4 [0:NPIX-1];

    always #5 clk = ~clk;

    pixel_shuffle_out #(
        .DATA_WIDTH(DW), .IN_CHANNELS(3), .IN_WIDTH(W), .IN_HEIGHT(H), .FRAC_BITS(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_rgb(out_rgb), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol)
    );

    pixel_shuffle_out #(
        .DATA_WIDTH(DW), .IN_CHANNELS(3), .IN_WIDTH(W), .IN_HEIGHT(H), .FRAC_BITS(4)
    ) u_dut_f4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready4), .out_rgb(out_rgb4), .out_valid(out_valid4),
        .out_ready(out_ready), .out_sof(out_sof4), .out_eol(out_eol4)
    );

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic int floor_div(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    // Output pixel idx (raster order, possibly spanning several frames).
    function automatic logic [23:0] model_pix(input int idx, input int frac);
        int f, p, ox, oy, x, y, dx, dy, raw, q;
        logic [LW-1:0] w;
        logic [23:0]   r;
        f  = idx / NPIX;  p  = idx % NPIX;
        oy = p / OW;      ox = p % OW;
        x  = ox / 2;      dx = ox % 2;
        y  = oy / 2;      dy = oy % 2;
        w  = fr[f*NIN + y*W + x];
        r  = '0;
        for (int c = 0; c < 3; c++) begin
            raw = int'($signed(w[(c*4 + dy*2 + dx)*DW +: DW]));
            q   = floor_div(raw, 1 << frac);
            r[(2-c)*8 +: 8] = (q < 0) ? 8'd0 : (q > 255) ? 8'd255 : 8'(q);
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_lane();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 16'h0FFF));
            2:       return 16'($urandom_range(0, 16'h7FFF));
            default: return 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        endcase
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < NL; k++)
                fr[i][k*DW +: DW] = rand_lane();
    endtask

    // Streams nfr frames from fr[]; mode 0 = always ready/valid, mode 1 =
    // random gaps on both sides. stop_at > 0 ends after that many pixels.
    task automatic run(input int nfr, input int mode, input int stop_at);
        int in_idx, out_idx, cyc, sofs, eols, lim, budget;
        bit acc_pend, stall_prev;
        in_idx = 0; out_idx = 0; cyc = 0; sofs = 0; eols = 0;
        acc_pend = 1'b0; stall_prev = 1'b0;
        lim    = (stop_at > 0) ? stop_at : nfr * NPIX;
        budget = 40 * nfr * NPIX + 200;
        in_valid = 1'b0;
        while (out_idx < lim && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (acc_pend) in_idx++;
            if (in_idx >= nfr * NIN) begin
                in_valid = 1'b0;
            end else if (acc_pend || !in_valid) begin
                in_data  = fr[in_idx];
                in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            acc_pend  = in_valid && in_ready;
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (stall_prev) check("hold_valid", out_valid, 1);
            if (out_valid) begin
                check("rgb",        out_rgb,  model_pix(out_idx, 8));
                check("rgb_f4",     out_rgb4, model_pix(out_idx, 4));
                check("sof",        out_sof,  ((out_idx % NPIX) == 0));
                check("eol",        out_eol,  ((out_idx % OW) == OW - 1));
                check("sof_f4",     out_sof4, ((out_idx % NPIX) == 0));
                check("eol_f4",     out_eol4, ((out_idx % OW) == OW - 1));
                check("valid_f4",   out_valid4, 1);
                check("ready_busy", in_ready, 0);
                if (out_ready) begin
                    obs[out_idx % NPIX]  = out_rgb;
                    obs4[out_idx % NPIX] = out_rgb4;
                    sofs += int'(out_sof);
                    eols += int'(out_eol);
                    out_idx++;
                end
            end
            stall_prev = out_valid && !out_ready;
        end
        if (out_idx < lim) check("timeout", out_idx, lim);
        if (stop_at == 0) begin
            check("sof_count", sofs, nfr);
            check("eol_count", eols, nfr * 2 * H);
        end
    endtask

    initial begin
        // Reset held with input pending.
        rst_n = 1'b0; in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_rgb",   out_rgb,   0);
        check("rst_sof",       out_sof,   0);
        check("rst_eol",       out_eol,   0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        in_valid = 1'b0;

        // Lane ordering: lane k carries integer value k+1.
        for (int i = 0; i < NIN; i++)
            for (int k = 0; k < NL; k++)
                fr[i][k*DW +: DW] = 16'((k + 1) << 8);
        run(1, 0, 0);
        check("order_top_dx0", obs[0],      24'h010509);
        check("order_top_dx1", obs[1],      24'h02060A);
        check("order_bot_dx0", obs[OW],     24'h03070B);
        check("order_bot_dx1", obs[OW + 1], 24'h04080C);

        // Saturation corners, rest random.
        fill_random(NIN);
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                fr[0][(0*4 + dy*2 + dx)*DW +: DW] = 16'h7FFF;
                fr[0][(1*4 + dy*2 + dx)*DW +: DW] = 16'h8000;
                fr[0][(2*4 + dy*2 + dx)*DW +: DW] = 16'h00FF;
            end
        for (int k = 0; k < NL; k++) fr[1][k*DW +: DW] = 16'h0180;
        run(1, 0, 0);
        check("sat_f8",      obs[0],  24'h7F0000);
        check("sat_f8_bot",  obs[OW], 24'h7F0000);
        check("sat_f4",      obs4[0], 24'hFF000F);
        check("half_f8",     obs[2],  24'h010101);
        check("half_f4",     obs4[2], 24'h181818);

        // Same random frame without and with backpressure.
        fill_random(NIN);
        run(1, 0, 0);
        run(1, 1, 0);

        // Two back-to-back frames.
        fill_random(2 * NIN);
        run(2, 0, 0);

        // Reset during the drain of low-res row 3, then a fresh frame.
        fill_random(NIN);
        run(1, 1, 7 * OW + 2);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",  in_ready,  0);
        check("midrst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill_random(NIN);
        run(1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
